// File: rtl/fb_ram_arbiter_if.sv
// Bus bundle between the column RAM arbiter, its two requesters and the single-port RAM.
// The slave modport is the arbiter; the master modport is the requester/RAM side.
interface fb_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 24
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [ADDR_W:0]   ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        output rd_data, rd_valid, wr_ready, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        input  rd_data, rd_valid, wr_ready, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/fb_ram_arbiter.sv
// Arbitrates the double-banked column RAM between the real-time reader (priority) and the
// frame writer, with a bounded-wait forced write slot and SOF-synchronised bank swapping.
module fb_ram_arbiter #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned MAX_WAIT = 4   // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SOF,
    input  logic                 wr_frame_done,
    output logic                 fb_clk_enable,
    output logic                 disp_bank,
    fb_ram_arbiter_if.slave      bus
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic       disp_bank_q, disp_bank_d;
    logic       pending_swap_q, pending_swap_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       rd_valid_q, rd_valid_d;

    logic force_w, wr_block, grant_w, grant_r, wr_sel, do_swap;

    always_comb begin
        force_w  = (wait_cnt_q == MaxWait);
        wr_block = pending_swap_q;
        grant_w  = bus.wr_valid & ~wr_block & (~bus.rd_req | force_w);
        grant_r  = bus.rd_req & ~grant_w;
        // Reset masks every strobe reaching the RAM and the framebuffer.
        wr_sel   = grant_w & ~rst;
    end

    assign bus.wr_ready  = wr_sel;
    assign bus.ram_we    = wr_sel;
    assign fb_clk_enable = ~rst & ~(bus.rd_req & grant_w);
    assign bus.ram_wdata = wr_sel ? bus.wr_data : '0;
    assign bus.ram_addr  = rst    ? '0 :
                           wr_sel ? {~disp_bank_q, bus.wr_addr} :
                                    {disp_bank_q, bus.rd_addr};
    assign bus.rd_data   = bus.ram_rdata;
    assign bus.rd_valid  = rd_valid_q;
    assign disp_bank     = disp_bank_q;

    always_comb begin
        do_swap        = SOF & (pending_swap_q | wr_frame_done);
        disp_bank_d    = disp_bank_q ^ do_swap;
        pending_swap_d = do_swap ? 1'b0 : (pending_swap_q | wr_frame_done);
        rd_valid_d     = grant_r;

        wait_cnt_d = wait_cnt_q;
        if (grant_w || !bus.wr_valid || wr_block) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != MaxWait) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_bank_q    <= 1'b0;
            pending_swap_q <= 1'b0;
            wait_cnt_q     <= 4'd0;
            rd_valid_q     <= 1'b0;
        end else begin
            disp_bank_q    <= disp_bank_d;
            pending_swap_q <= pending_swap_d;
            wait_cnt_q     <= wait_cnt_d;
            rd_valid_q     <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Directed table-driven bench for fb_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_fb_ram_arbiter;

    logic clk;
    logic rst;
    logic sof;
    logic fdone;
    logic fb_clk_enable;
    logic disp_bank;

    fb_ram_arbiter_if #(.ADDR_W(7), .DATA_W(24)) bus ();

    fb_ram_arbiter #(.ADDR_W(7), .DATA_W(24), .MAX_WAIT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .SOF           (sof),
        .wr_frame_done (fdone),
        .fb_clk_enable (fb_clk_enable),
        .disp_bank     (disp_bank),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] mem [256];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    typedef struct {
        logic        rst, sof, fdone, rd_req;
        logic [6:0]  rd_addr;
        logic        wr_valid;
        logic [6:0]  wr_addr;
        logic [23:0] wr_data;
        logic        e_wr_ready, e_fbce, e_we;
        logic [7:0]  e_ram_addr;
        logic        e_disp, e_rdv, e_pend;
        logic [3:0]  e_wait;
        logic        chk_rd;
        logic [23:0] e_rdata;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic r, logic s, logic fd, logic rq, logic [6:0] ra,
                                logic wv, logic [6:0] wa, logic [23:0] wd,
                                logic ewr, logic efb, logic ewe, logic [7:0] eaddr,
                                logic edisp, logic erdv, logic epend, logic [3:0] ewait);
        vec_t v;
        v.rst = r; v.sof = s; v.fdone = fd; v.rd_req = rq; v.rd_addr = ra;
        v.wr_valid = wv; v.wr_addr = wa; v.wr_data = wd;
        v.e_wr_ready = ewr; v.e_fbce = efb; v.e_we = ewe; v.e_ram_addr = eaddr;
        v.e_disp = edisp; v.e_rdv = erdv; v.e_pend = epend; v.e_wait = ewait;
        v.chk_rd = 1'b0; v.e_rdata = 24'h0;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, check just before the active edge, then advance past it.
    task automatic apply(string tag, vec_t v);
        rst = v.rst; sof = v.sof; fdone = v.fdone;
        bus.rd_req = v.rd_req; bus.rd_addr = v.rd_addr;
        bus.wr_valid = v.wr_valid; bus.wr_addr = v.wr_addr; bus.wr_data = v.wr_data;
        @(negedge clk);
        chk({tag, " wr_ready"},  32'(bus.wr_ready),       32'(v.e_wr_ready));
        chk({tag, " fb_ce"},     32'(fb_clk_enable),      32'(v.e_fbce));
        chk({tag, " ram_we"},    32'(bus.ram_we),         32'(v.e_we));
        chk({tag, " ram_addr"},  32'(bus.ram_addr),       32'(v.e_ram_addr));
        chk({tag, " ram_wdata"}, 32'(bus.ram_wdata),      v.e_we ? 32'(v.wr_data) : 32'h0);
        chk({tag, " disp_bank"}, 32'(disp_bank),          32'(v.e_disp));
        chk({tag, " rd_valid"},  32'(bus.rd_valid),       32'(v.e_rdv));
        chk({tag, " pending"},   32'(dut.pending_swap_q), 32'(v.e_pend));
        chk({tag, " wait_cnt"},  32'(dut.wait_cnt_q),     32'(v.e_wait));
        if (v.chk_rd) chk({tag, " rd_data"}, 32'(bus.rd_data), 32'(v.e_rdata));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic g;

        // Reset state, then writer-only burst to the back bank.
        vecs.push_back(mk(1, 0, 0, 1, 7'h05, 1, 7'h05, 24'h0, 0, 0, 0, 8'h00, 0, 0, 0, 4'd0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 0, 0, 0, 7'h00, 1, 7'(i), 24'h000100 + 24'(i),
                              1, 1, 1, 8'h80 | 8'(i), 0, 0, 0, 4'd0));
        // Contention: forced write slot every MAX_WAIT+1 cycles.
        for (int k = 1; k <= 15; k++) begin
            g = (k % 5 == 0);
            vecs.push_back(mk(0, 0, 0, 1, 7'h10, 1, 7'h20, 24'h5A5A00 + 24'(k),
                              g, ~g, g, g ? 8'hA0 : 8'h10, 0,
                              logic'(k > 1 && (k - 1) % 5 != 0), 0, 4'((k - 1) % 5)));
        end
        // SOF with nothing pending, then frame_done blocks writes until SOF has passed.
        vecs.push_back(mk(0, 1, 0, 0, 7'h10, 0, 7'h00, 24'h0, 0, 1, 0, 8'h10, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 0, 7'h10, 0, 7'h00, 24'h0, 0, 1, 0, 8'h10, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 0, 7'h10, 1, 7'h07, 24'h777777, 1, 1, 1, 8'h87, 0, 0, 0, 4'd0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 0, 7'h10, 1, 7'h07, 24'h777777,
                              0, 1, 0, 8'h10, 0, 0, 1, 4'd0));
        vecs.push_back(mk(0, 1, 0, 0, 7'h10, 1, 7'h07, 24'h777777, 0, 1, 0, 8'h10, 0, 0, 1, 4'd0));
        vecs.push_back(mk(0, 0, 0, 0, 7'h10, 1, 7'h07, 24'h777777, 1, 1, 1, 8'h07, 1, 0, 0, 4'd0));

        rst = 1'b1; sof = 1'b0; fdone = 1'b0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

        // Mid-operation reset with wait_cnt=3 and a read in flight.
        apply("rst_a", mk(0, 0, 0, 1, 7'h11, 1, 7'h07, 24'h1, 0, 1, 0, 8'h91, 1, 0, 0, 4'd0));
        apply("rst_b", mk(0, 0, 0, 1, 7'h11, 1, 7'h07, 24'h1, 0, 1, 0, 8'h91, 1, 1, 0, 4'd1));
        apply("rst_c", mk(0, 0, 0, 1, 7'h11, 1, 7'h07, 24'h1, 0, 1, 0, 8'h91, 1, 1, 0, 4'd2));
        apply("rst_d", mk(1, 0, 0, 1, 7'h11, 1, 7'h07, 24'h1, 0, 0, 0, 8'h00, 1, 1, 0, 4'd3));
        apply("rst_e", mk(0, 0, 0, 0, 7'h00, 0, 7'h00, 24'h0, 0, 1, 0, 8'h00, 0, 0, 0, 4'd0));

        // Write, frame_done, SOF, then read back from the new display bank.
        apply("swp_w",  mk(0, 0, 0, 0, 7'h00, 1, 7'h03, 24'hABCDEF, 1, 1, 1, 8'h83, 0, 0, 0, 4'd0));
        apply("swp_fd", mk(0, 0, 1, 0, 7'h00, 0, 7'h00, 24'h0, 0, 1, 0, 8'h00, 0, 0, 0, 4'd0));
        apply("swp_sf", mk(0, 1, 0, 0, 7'h00, 0, 7'h00, 24'h0, 0, 1, 0, 8'h00, 0, 0, 1, 4'd0));
        apply("swp_rd", mk(0, 0, 0, 1, 7'h03, 0, 7'h00, 24'h0, 0, 1, 0, 8'h83, 1, 0, 0, 4'd0));
        v = mk(0, 0, 0, 0, 7'h00, 0, 7'h00, 24'h0, 0, 1, 0, 8'h80, 1, 1, 0, 4'd0);
        v.chk_rd = 1'b1; v.e_rdata = 24'hABCDEF;
        apply("swp_dt", v);

        // Write granted alongside frame_done and SOF lands in the pre-swap write bank.
        apply("sim_w",  mk(0, 1, 1, 0, 7'h00, 1, 7'h09, 24'h123456, 1, 1, 1, 8'h09, 1, 0, 0, 4'd0));
        apply("sim_rd", mk(0, 0, 0, 1, 7'h09, 0, 7'h00, 24'h0, 0, 1, 0, 8'h09, 0, 0, 0, 4'd0));
        v = mk(0, 0, 0, 0, 7'h00, 0, 7'h00, 24'h0, 0, 1, 0, 8'h00, 0, 1, 0, 4'd0);
        v.chk_rd = 1'b1; v.e_rdata = 24'h123456;
        apply("sim_dt", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_ram_arbiter.md
Name: fb_ram_arbiter

Overview:
- Shares the single-port column RAM between two requesters: the framebuffer column reader (real-time, priority) and the pixel writer that loads frames from the input link.
- The RAM is double-banked. The reader always reads the display bank; the writer always writes the other bank. Banks swap only on a position SOF, after the writer has declared its frame complete.
- The reader is stalled through the framebuffer clock-enable when the writer must be served, so the writer is never starved.

Parameters:
- ADDR_W, 7, per-bank RAM address width (matches the framebuffer ram_addr)
- DATA_W, 24, pixel width in bits
- MAX_WAIT, 4, max consecutive cycles a valid write may be refused before a write slot is forced; legal range 1..15

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- SOF  in  1  position start-of-frame pulse, 1 cycle
- rd_req  in  1  reader needs the RAM this cycle
- rd_addr  in  ADDR_W  reader address within the display bank
- rd_data  out  DATA_W  read data, passthrough of ram_rdata
- rd_valid  out  1  rd_data valid; asserted the cycle after a read grant
- fb_clk_enable  out  1  clock-enable to the framebuffer; 0 = reader stalled
- wr_valid  in  1  writer has a pixel
- wr_ready  out  1  write accepted this cycle when wr_valid=1
- wr_addr  in  ADDR_W  writer address within the write bank
- wr_data  in  DATA_W  pixel to write
- wr_frame_done  in  1  pulse: the writer has finished loading a frame
- ram_addr  out  ADDR_W+1  {bank, address} to the RAM
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency
- disp_bank  out  1  current display bank, for debug

Behaviour:
- State registers: disp_bank, pending_swap, wait_cnt (4 bits), rd_valid.
- Reset values: disp_bank=0, pending_swap=0, wait_cnt=0, rd_valid=0.
- While rst=1, outputs are forced to: wr_ready=0, ram_we=0, fb_clk_enable=0, ram_addr=0.
- Control signals:
  - force_w = (wait_cnt == MAX_WAIT)
  - wr_block = pending_swap
- Grant rules (combinational, one per cycle):
  - grant_w = wr_valid & ~wr_block & (~rd_req | force_w)
  - grant_r = rd_req & ~grant_w
  - wr_ready = grant_w
  - fb_clk_enable = ~(rd_req & grant_w). The reader holds its request and address while stalled and is served in the next cycle.
- RAM mux:
  - On grant_w: ram_addr = {~disp_bank, wr_addr}, ram_we=1, ram_wdata = wr_data.
  - Otherwise: ram_addr = {disp_bank, rd_addr}, ram_we=0, ram_wdata = 0.
- rd_valid <= grant_r. rd_data = ram_rdata at all times.
- wait_cnt update:
  - 0 if grant_w, or ~wr_valid, or wr_block.
  - Otherwise wait_cnt+1, saturating at MAX_WAIT.
  - A forced slot therefore occurs at most once per MAX_WAIT+1 cycles. The reader stall duty cycle is bounded by 1/(MAX_WAIT+1).
- Swap sequencing:
  - wr_frame_done sets pending_swap. A wr_frame_done received while pending_swap=1 is ignored.
  - On SOF with pending_swap=1 (or wr_frame_done in the same cycle): toggle disp_bank and clear pending_swap.
  - On SOF with no pending swap: the bank is unchanged and the old frame is redisplayed.
- Simultaneous events:
  - A write granted in the same cycle as wr_frame_done goes to the pre-swap write bank.
  - A read granted in the SOF cycle uses the pre-toggle disp_bank. The new bank applies from the next cycle.
  - rd_valid issued the cycle after a swap still refers to the old bank's data. This is correct because the RAM latches the address on the grant cycle.
- Mid-operation reset: all state is cleared in one cycle and any in-flight read is dropped (rd_valid=0). Data already written to the RAM is not altered.

Test Plan:
1. Writer only, rd_req=0, 16 writes to addresses 0..15 → wr_ready=1 every cycle; ram_addr = 0x80|addr; ram_we=1; fb_clk_enable=1; wait_cnt stays 0.
2. rd_req held 1 and wr_valid held 1, MAX_WAIT=4 → wr_ready pulses on cycles 5, 10, 15; fb_clk_enable=0 exactly on those cycles; rd_valid follows each read grant by 1 cycle.
3. Write 0xABCDEF to addr 3, then wr_frame_done, then SOF, then read addr 3 → disp_bank toggles to 1 the cycle after SOF; rd_data=0xABCDEF with rd_valid=1.
4. SOF without a prior wr_frame_done → disp_bank unchanged. wr_frame_done, then a write attempt before SOF → wr_ready=0 until the SOF cycle has passed.
5. wr_frame_done and SOF in the same cycle as a granted write → the write lands in bank ~old disp_bank; disp_bank toggles; pending_swap=0 afterwards.
6. rst asserted for 1 cycle while wait_cnt=3 and a read is in flight → the next cycle shows rd_valid=0, disp_bank=0, wait_cnt=0; during rst, wr_ready=0 and ram_we=0.
